chip8_alu_exec: RTL and testbench

//  Multi-cycle executor for CHIP-8 8XYN register-register opcodes. Reads Vx/Vy from the

---
 rtl/chip8_alu_exec_pkg.sv | 27 ++
 rtl/chip8_alu_exec_if.sv | 28 ++
 rtl/chip8_alu_decode.sv | 66 ++++++
 rtl/chip8_alu_exec.sv | 138 +++++++++++++
 tb/tb_chip8_alu_exec.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chip8_alu_exec_pkg.sv
// Shared definitions for the CHIP-8 8XYN executor: ALU op codes, fixed register
// indices and the decoded-opcode record.
package chip8_alu_exec_pkg;

    typedef enum logic [2:0] {
        ALU_LD  = 3'd0,
        ALU_OR  = 3'd1,
        ALU_AND = 3'd2,
        ALU_XOR = 3'd3,
        ALU_ADD = 3'd4,
        ALU_SUB = 3'd5,
        ALU_SHR = 3'd6,
        ALU_SHL = 3'd7
    } alu_op_t;

    localparam logic [3:0] REG_VF        = 4'hF;
    localparam logic [3:0] OPC_ALU_GROUP = 4'h8;

    typedef struct packed {
        alu_op_t alu_op;
        logic    swap;       // operands exchanged before the ALU (SUBN)
        logic    writes_vf;  // WR_F step is taken
        logic    clear_vf;   // flag forced to 0 instead of the ALU carry
        logic    illegal;
    } alu_dec_t;

endpackage

// File: rtl/chip8_alu_exec_if.sv
// Bus bundle between the 8XYN executor, the instruction decoder, the V register file
// and the ALU. master = executor side, slave = environment side.
interface chip8_alu_exec_if;
    logic        start;
    logic [15:0] opcode;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [3:0]  reg_addr;
    logic        reg_we;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic [7:0]  alu_x;
    logic [7:0]  alu_y;
    logic [2:0]  alu_op;
    logic [7:0]  alu_out;
    logic        alu_carry;

    modport master (
        input  start, opcode, reg_rdata, alu_out, alu_carry,
        output busy, done, illegal, reg_addr, reg_we, reg_wdata, alu_x, alu_y, alu_op
    );

    modport slave (
        output start, opcode, reg_rdata, alu_out, alu_carry,
        input  busy, done, illegal, reg_addr, reg_we, reg_wdata, alu_x, alu_y, alu_op
    );
endinterface

// File: rtl/chip8_alu_decode.sv
// Combinational 8XYN decoder: opcode group + N nibble -> ALU op, swap, VF handling.
// CHIP8_VF_RESET_EN: OR/AND/XOR also write VF=0 (COSMAC quirk).
module chip8_alu_decode
    import chip8_alu_exec_pkg::*;
(
    input  logic [3:0] group,
    input  logic [3:0] n,
    output alu_dec_t   dec
);

`ifdef CHIP8_VF_RESET_EN
    localparam logic LOGIC_OPS_WRITE_VF = 1'b1;
`else
    localparam logic LOGIC_OPS_WRITE_VF = 1'b0;
`endif

    always_comb begin
        dec = '0;
        if (group != OPC_ALU_GROUP) begin
            dec.illegal = 1'b1;
        end else begin
            case (n)
                4'h0: dec.alu_op = ALU_LD;
                4'h1: begin
                    dec.alu_op    = ALU_OR;
                    dec.clear_vf  = 1'b1;
                    dec.writes_vf = LOGIC_OPS_WRITE_VF;
                end
                4'h2: begin
                    dec.alu_op    = ALU_AND;
                    dec.clear_vf  = 1'b1;
                    dec.writes_vf = LOGIC_OPS_WRITE_VF;
                end
                4'h3: begin
                    dec.alu_op    = ALU_XOR;
                    dec.clear_vf  = 1'b1;
                    dec.writes_vf = LOGIC_OPS_WRITE_VF;
                end
                4'h4: begin
                    dec.alu_op    = ALU_ADD;
                    dec.writes_vf = 1'b1;
                end
                4'h5: begin
                    dec.alu_op    = ALU_SUB;
                    dec.writes_vf = 1'b1;
                end
                4'h6: begin
                    dec.alu_op    = ALU_SHR;
                    dec.writes_vf = 1'b1;
                end
                // SUBN reuses the SUB datapath with Vx/Vy exchanged
                4'h7: begin
                    dec.alu_op    = ALU_SUB;
                    dec.swap      = 1'b1;
                    dec.writes_vf = 1'b1;
                end
                4'hE: begin
                    dec.alu_op    = ALU_SHL;
                    dec.writes_vf = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/chip8_alu_exec.sv
// Multi-cycle executor for CHIP-8 8XYN opcodes: reads Vx/Vy, runs the ALU, writes Vx then VF.
// Optional COSMAC VF-reset behaviour for OR/AND/XOR is selected by CHIP8_VF_RESET_EN.
module chip8_alu_exec
    import chip8_alu_exec_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    chip8_alu_exec_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_X,
        S_RD_Y,
        S_EXEC,
        S_WR_X,
        S_WR_F,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    alu_dec_t   dec;
    alu_dec_t   dec_q;
    logic [3:0] x_idx;
    logic [3:0] y_idx;
    logic [7:0] vx;
    logic [7:0] vy;
    logic [7:0] result;
    logic       flag;
    logic [7:0] y_val;

    chip8_alu_decode u_decode (
        .group (bus.opcode[15:12]),
        .n     (bus.opcode[3:0]),
        .dec   (dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = dec.illegal ? S_DONE : S_RD_X;
                end
            end
            S_RD_X:  state_nxt = S_RD_Y;
            S_RD_Y:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WR_X;
            S_WR_X:  state_nxt = dec_q.writes_vf ? S_WR_F : S_DONE;
            S_WR_F:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Opcode fields are captured only on accept, so later opcode/start activity is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_q  <= '0;
            x_idx  <= '0;
            y_idx  <= '0;
            vx     <= '0;
            vy     <= '0;
            result <= '0;
            flag   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        dec_q <= dec;
                        x_idx <= bus.opcode[11:8];
                        y_idx <= bus.opcode[7:4];
                    end
                end
                S_RD_Y: vx <= bus.reg_rdata;
                S_EXEC: begin
                    vy     <= bus.reg_rdata;
                    result <= bus.alu_out;
                    flag   <= bus.alu_carry & ~dec_q.clear_vf;
                end
                default: ;
            endcase
        end
    end

    // Vy arrives from the register file during EXEC and feeds the ALU directly.
    assign y_val = (state == S_EXEC) ? bus.reg_rdata : vy;

    always_comb begin
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.illegal   = 1'b0;
        bus.reg_addr  = '0;
        bus.reg_we    = 1'b0;
        bus.reg_wdata = '0;
        bus.alu_op    = dec_q.alu_op;
        bus.alu_x     = dec_q.swap ? y_val : vx;
        bus.alu_y     = dec_q.swap ? vx : y_val;
        case (state)
            S_RD_X: begin
                bus.busy     = 1'b1;
                bus.reg_addr = x_idx;
            end
            S_RD_Y: begin
                bus.busy     = 1'b1;
                bus.reg_addr = y_idx;
            end
            S_EXEC: bus.busy = 1'b1;
            S_WR_X: begin
                bus.busy      = 1'b1;
                bus.reg_addr  = x_idx;
                bus.reg_we    = 1'b1;
                bus.reg_wdata = result;
            end
            S_WR_F: begin
                bus.busy      = 1'b1;
                bus.reg_addr  = REG_VF;
                bus.reg_we    = 1'b1;
                bus.reg_wdata = {7'b0, flag};
            end
            S_DONE: begin
                bus.done    = 1'b1;
                bus.illegal = dec_q.illegal;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_chip8_alu_exec.sv
// Bench for chip8_alu_exec: register file and ALU models around the DUT, a per-cycle
// handshake checker and a register-level reference model of 8XYN semantics.
module tb_chip8_alu_exec;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    chip8_alu_exec_if bus ();

    chip8_alu_exec dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // V register file: synchronous read, one-cycle latency; preload port for setup.
    logic [7:0] rf [16];
    logic [7:0] exp_rf [16];
    logic       pl_we;
    logic [3:0] pl_addr;
    logic [7:0] pl_data;

    always @(posedge clk) begin
        bus.reg_rdata <= rf[bus.reg_addr];
        if (bus.reg_we) rf[bus.reg_addr] <= bus.reg_wdata;
        if (pl_we) rf[pl_addr] <= pl_data;
    end

    // CHIP-8 ALU, SUB borrow flag = X > Y strictly.
    logic [8:0] alu_sum;
    assign alu_sum = {1'b0, bus.alu_x} + {1'b0, bus.alu_y};

    always_comb begin
        bus.alu_out   = 8'h00;
        bus.alu_carry = 1'b0;
        case (bus.alu_op)
            3'd0: bus.alu_out = bus.alu_y;
            3'd1: bus.alu_out = bus.alu_x | bus.alu_y;
            3'd2: bus.alu_out = bus.alu_x & bus.alu_y;
            3'd3: bus.alu_out = bus.alu_x ^ bus.alu_y;
            3'd4: begin
                bus.alu_out   = alu_sum[7:0];
                bus.alu_carry = alu_sum[8];
            end
            3'd5: begin
                bus.alu_out   = bus.alu_x - bus.alu_y;
                bus.alu_carry = bus.alu_x > bus.alu_y;
            end
            3'd6: begin
                bus.alu_out   = bus.alu_x >> 1;
                bus.alu_carry = bus.alu_x[0];
            end
            default: begin
                bus.alu_out   = bus.alu_x << 1;
                bus.alu_carry = bus.alu_x[7];
            end
        endcase
    end

    // Transaction bookkeeping: driver writes launch_id/exp_*, checker owns the rest.
    int launch_id   = 0;
    int seen_id     = 0;
    int k           = 0;
    int exp_lat     = 0;
    bit exp_ill     = 1'b0;
    bit act         = 1'b0;
    int done_count  = 0;
    int last_done_k = 0;

    always @(negedge clk) begin
        if (reset) begin
            act     = 1'b0;
            seen_id = launch_id;
        end else begin
            if (launch_id != seen_id) begin
                seen_id = launch_id;
                act     = 1'b1;
                k       = 0;
            end
            if (act) begin
                k++;
                chk("busy", bus.busy, k < exp_lat);
                chk("done", bus.done, k == exp_lat);
                chk("illegal", bus.illegal, (k == exp_lat) && exp_ill);
                chk("reg_we", bus.reg_we, !exp_ill && (k == 4 || (k == 5 && exp_lat == 6)));
                if (k >= exp_lat) act = 1'b0;
            end else begin
                chk("idle_busy", bus.busy, 1'b0);
                chk("idle_done", bus.done, 1'b0);
                chk("idle_we", bus.reg_we, 1'b0);
            end
            if (bus.done) begin
                done_count++;
                last_done_k = k;
            end
        end
    end

    // Reference semantics of one 8XYN opcode on exp_rf; returns latency and legality.
    task automatic model(input logic [15:0] opc, output int lat, output bit ill);
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] vx;
        logic [7:0] vy;
        logic [8:0] s;
        x   = opc[11:8];
        y   = opc[7:4];
        vx  = exp_rf[x];
        vy  = exp_rf[y];
        ill = 1'b0;
        lat = 6;
        if (opc[15:12] != 4'h8) begin
            ill = 1'b1;
        end else begin
            case (opc[3:0])
                4'h0: begin exp_rf[x] = vy; lat = 5; end
                4'h1, 4'h2, 4'h3: begin
                    if (opc[3:0] == 4'h1) exp_rf[x] = vx | vy;
                    else if (opc[3:0] == 4'h2) exp_rf[x] = vx & vy;
                    else exp_rf[x] = vx ^ vy;
`ifdef CHIP8_VF_RESET_EN
                    exp_rf[15] = 8'h00;
                    lat = 6;
`else
                    lat = 5;
`endif
                end
                4'h4: begin
                    s = {1'b0, vx} + {1'b0, vy};
                    exp_rf[x]  = s[7:0];
                    exp_rf[15] = {7'b0, s[8]};
                end
                4'h5: begin exp_rf[x] = vx - vy; exp_rf[15] = (vx > vy) ? 8'h01 : 8'h00; end
                4'h6: begin exp_rf[x] = vx >> 1; exp_rf[15] = {7'b0, vx[0]}; end
                4'h7: begin exp_rf[x] = vy - vx; exp_rf[15] = (vy > vx) ? 8'h01 : 8'h00; end
                4'hE: begin exp_rf[x] = vx << 1; exp_rf[15] = {7'b0, vx[7]}; end
                default: ill = 1'b1;
            endcase
        end
        if (ill) lat = 1;
    endtask

    task automatic set_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        exp_rf[a] = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic cmp_regs();
        for (int r = 0; r < 16; r++) chk($sformatf("V%0h", r), rf[r], exp_rf[r]);
    endtask

    // poke: re-assert start while busy (cycle 2) and in DONE; both must be ignored.
    task automatic run_op(input logic [15:0] opc, input bit poke);
        int lat;
        bit ill;
        int target;
        bit got;
        model(opc, lat, ill);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = opc;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.opcode = 16'h8FF4;
        exp_lat    = lat;
        exp_ill    = ill;
        target     = done_count + 1;
        launch_id++;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            if (poke) bus.start = (k == 2) || (k == exp_lat);
            if (done_count >= target) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", got, 1'b1);
        if (poke) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        cmp_regs();
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.opcode = 16'h0000;
        pl_we      = 1'b0;
        pl_addr    = 4'h0;
        pl_data    = 8'h00;
        #3;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_illegal", bus.illegal, 1'b0);
        chk("rst_we", bus.reg_we, 1'b0);
        chk("rst_addr", bus.reg_addr, 4'h0);
        chk("rst_wdata", bus.reg_wdata, 8'h00);
        chk("rst_alu_x", bus.alu_x, 8'h00);
        chk("rst_alu_y", bus.alu_y, 8'h00);
        chk("rst_alu_op", bus.alu_op, 3'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 16; r++) set_reg(r[3:0], 8'(8'h20 + r));

        // ADD without and with carry
        set_reg(4'h1, 8'h0F); set_reg(4'h2, 8'h01); set_reg(4'hF, 8'h55);
        run_op(16'h8124, 1'b0);
        chk("add_v1", rf[1], 8'h10);
        chk("add_vf", rf[15], 8'h00);
        chk("add_lat", last_done_k, 6);
        set_reg(4'h1, 8'hFF);
        run_op(16'h8124, 1'b0);
        chk("addc_v1", rf[1], 8'h00);
        chk("addc_vf", rf[15], 8'h01);

        // SUBN / SUB
        set_reg(4'h3, 8'h05); set_reg(4'h4, 8'h0A);
        run_op(16'h8347, 1'b0);
        chk("subn_v3", rf[3], 8'h05);
        chk("subn_vf", rf[15], 8'h01);
        set_reg(4'h3, 8'h05);
        run_op(16'h8345, 1'b0);
        chk("sub_v3", rf[3], 8'hFB);
        chk("sub_vf", rf[15], 8'h00);

        // X = F: flag overwrites the shifted result
        set_reg(4'hF, 8'h81);
        run_op(16'h8F0E, 1'b0);
        chk("shl_vf", rf[15], 8'h01);
        set_reg(4'hF, 8'h81);
        run_op(16'h8F06, 1'b0);
        chk("shr_vf", rf[15], 8'h01);

        // logic op VF handling
        set_reg(4'hF, 8'h07); set_reg(4'h1, 8'h30); set_reg(4'h2, 8'h0C);
        run_op(16'h8121, 1'b0);
        chk("or_v1", rf[1], 8'h3C);
`ifdef CHIP8_VF_RESET_EN
        chk("or_vf", rf[15], 8'h00);
        chk("or_lat", last_done_k, 6);
`else
        chk("or_vf", rf[15], 8'h07);
        chk("or_lat", last_done_k, 5);
`endif
        run_op(16'h8562, 1'b0);
        run_op(16'h8783, 1'b0);

        // LD and a busy/DONE start poke
        set_reg(4'h0, 8'h11); set_reg(4'h1, 8'hA5);
        run_op(16'h8010, 1'b1);
        chk("ld_v0", rf[0], 8'hA5);
        chk("ld_lat", last_done_k, 5);
        set_reg(4'h9, 8'h40); set_reg(4'hA, 8'h41);
        run_op(16'h89A5, 1'b1);
        chk("sub_eq_v9", rf[9], 8'hFF);
        chk("sub_eq_vf", rf[15], 8'h00);

        // illegal opcodes
        run_op(16'h8128, 1'b0);
        chk("ill8_lat", last_done_k, 1);
        run_op(16'h9120, 1'b0);
        chk("ill9_lat", last_done_k, 1);

        // reset while in EXEC
        set_reg(4'h1, 8'h0F); set_reg(4'h2, 8'h01);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = 16'h8124;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        exp_lat   = 6;
        exp_ill   = 1'b0;
        launch_id++;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_busy", bus.busy, 1'b0);
        chk("rstmid_we", bus.reg_we, 1'b0);
        chk("rstmid_done", bus.done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        cmp_regs();
        run_op(16'h8124, 1'b0);
        chk("post_rst_v1", rf[1], 8'h10);
        chk("post_rst_lat", last_done_k, 6);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
